dwconv_seq: RTL and testbench
=============================

# dwconv_seq

Frame sequencer for the depthwise-convolution datapath. It walks a feature map stored channel-innermost in SRAM, one 16-bit read per cycle. Each pixel is paired with that channel's 3x3 weight word (144 b) and 16-bit bias from a weight ROM, and the stream is presented to the datapath as `dw_in_valid`-qualified beats. It then counts datapath results until the frame is complete and reports done/error to the layer controller.

## Interface
- `IMG_W`, 176: columns per row
- `IMG_H`, 176: rows per frame
- `CH`, 256: channels per pixel, innermost in memory
- `ADDR_W`, 23: feature-map address width; must hold IMG_W*IMG_H*CH-1
- `OUT_TOTAL`, 7750656: datapath results expected per frame, (IMG_H-2)*(IMG_W-2)*CH
- `DRAIN_MAX`, 1024: idle cycles allowed in DRAIN before timeout
---
- `clk`  in  1: clock
- `rst_n`  in  1: reset, asynchronous, active-low
- `start`  in  1: frame start pulse, honoured in IDLE only
- `abort`  in  1: synchronous cancel
- `hold`  in  1: suppress read issue this cycle (downstream back-pressure)
- `fm_ren`  out  1: feature-map read enable
- `fm_addr`  out  ADDR_W: feature-map address
- `fm_rdata`  in  16: read data, valid 1 cycle after `fm_ren`
- `wt_ren`  out  1: weight/bias ROM read enable, equal to `fm_ren`
- `wt_addr`  out  8: channel index
- `wt_rdata`  in  144: 9x16 weights, 1-cycle latency
- `bias_rdata`  in  16: bias, 1-cycle latency
- `dw_in_valid`  out  1: beat valid to datapath
- `dw_in_data`  out  16: copy of `fm_rdata`, combinational
- `dw_weight`  out  144: copy of `wt_rdata`, combinational
- `dw_bias`  out  16: copy of `bias_rdata`, combinational
- `dw_out_valid`  in  1: one datapath result produced
- `busy`  out  1: high in ISSUE and DRAIN
- `done`  out  1: one-cycle pulse at frame completion
- `err`  out  1: sticky error flag

## Operation
- States:
  - IDLE: `start`=1 → ISSUE, clears counters and `err`.
  - ISSUE: one read per cycle while `hold`=0; after the last address is issued → DRAIN.
  - DRAIN: when `out_cnt`==OUT_TOTAL → DONE; if the DRAIN idle timer reaches DRAIN_MAX → DONE with `err`=1.
  - DONE: one cycle, `done`=1, then → IDLE.
- Counters:
  - `ch` 0..CH-1, innermost; `col` 0..IMG_W-1; `row` 0..IMG_H-1.
  - `fm_addr` is a linear counter from 0, +1 per issued read.
  - `wt_addr` = `ch`.
- Wrap: `ch`==CH-1 → 0 and `col`+1. `col`==IMG_W-1 with `ch` wrap → 0 and `row`+1. Last read is row IMG_H-1, col IMG_W-1, ch CH-1, address IMG_W*IMG_H*CH-1.
- `out_cnt`: 24 b, +1 on each `dw_out_valid` in ISSUE or DRAIN. The DRAIN timer clears on any `dw_out_valid`.
- `err` is set by any of:
  - a DRAIN timeout;
  - `dw_out_valid` while in IDLE or DONE;
  - `out_cnt` exceeding OUT_TOTAL.
- `err` holds until the next accepted `start`.
- `abort`=1 in any state → IDLE next cycle, with no further `fm_ren`. An in-flight read still produces its `dw_in_valid` beat. Counters clear and `done` is not pulsed.
- `start` outside IDLE is ignored. `start` and `abort` together: `abort` wins.

## Timing
- Reset values:
  - state IDLE; all counters 0.
  - `fm_ren`, `wt_ren`, `dw_in_valid`, `busy`, `done`, `err` = 0.
  - `fm_addr` = 0, `wt_addr` = 0.
- `start` at cycle t → first `fm_ren` at t+1 (if `hold`=0) → first `dw_in_valid` at t+2.
- `dw_in_valid` is `fm_ren` registered once. Data, weight and bias are passed combinationally from the memories in that same cycle.
- `hold`=1 in cycle t: no `fm_ren` at t and no beat at t+1. The beat for the read issued at t-1 still appears at t. Counters freeze.
- Throughput: 1 beat/cycle with `hold`=0. A full frame issues IMG_W*IMG_H*CH reads in exactly that many non-held ISSUE cycles.
- ISSUE→DRAIN happens in the cycle after the last `fm_ren`. `busy` stays 1 through DRAIN and drops in the DONE cycle.

## Configuration
- `DWCONV_SEQ_PERF_EN` defined adds two outputs:
  - `perf_cycles` (32 b): counts cycles in ISSUE and DRAIN.
  - `perf_stalls` (32 b): counts ISSUE cycles with `hold`=1.
  - Both clear on accepted `start`, are held after DONE, and reset to 0.
- Undefined: neither port nor its counters exist, and all other behaviour is identical.

## Test plan
- Small frame (IMG_W=4, IMG_H=3, CH=2, OUT_TOTAL=4), `hold`=0:
  - `fm_addr` runs 0..23 on 24 consecutive cycles and `wt_addr` alternates 0,1.
  - 4 `dw_out_valid` pulses → `done` one cycle, `err`=0.
- Same frame with `hold`=1 on cycles 3-5 of ISSUE: no beats on cycles 4-6, address sequence unbroken, still 24 beats total.
- `abort` at address 10: `fm_ren` stops next cycle, one trailing beat, back to IDLE, no `done`. A new `start` then restarts at `fm_addr`=0.
- Only 3 of 4 results with DRAIN_MAX=16: `done` 16 cycles after the last result, `err`=1, which clears on the next `start`.
- `dw_out_valid` in IDLE → `err`=1. `start` during ISSUE is ignored (address sequence unchanged).
- With `DWCONV_SEQ_PERF_EN`, small frame plus 3 hold cycles: `perf_stalls`=3 and `perf_cycles` = 27 + DRAIN length.

Source files
------------

// File: rtl/dwconv_seq.sv
// Depthwise-conv frame sequencer: walks the feature map channel-innermost, pairs each pixel with
// its channel weights/bias, then counts datapath results to frame end. Optional DWCONV_SEQ_PERF_EN.
module dwconv_seq #(
  parameter int IMG_W     = 176,
  parameter int IMG_H     = 176,
  parameter int CH        = 256,
  parameter int ADDR_W    = 23,
  parameter int OUT_TOTAL = (IMG_H-2)*(IMG_W-2)*CH,
  parameter int DRAIN_MAX = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              hold,
  output logic              fm_ren,
  output logic [ADDR_W-1:0] fm_addr,
  input  logic [15:0]       fm_rdata,
  output logic              wt_ren,
  output logic [7:0]        wt_addr,
  input  logic [143:0]      wt_rdata,
  input  logic [15:0]       bias_rdata,
  output logic              dw_in_valid,
  output logic [15:0]       dw_in_data,
  output logic [143:0]      dw_weight,
  output logic [15:0]       dw_bias,
  input  logic              dw_out_valid,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef DWCONV_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_stalls
`endif
);
  localparam int CW = (CH    > 1) ? $clog2(CH)    : 1;
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int TW = $clog2(DRAIN_MAX+1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
  state_t state_q, state_d;

  logic [CW-1:0]     ch_q;
  logic [XW-1:0]     col_q;
  logic [YW-1:0]     row_q;
  logic [ADDR_W-1:0] addr_q;
  logic [23:0]       out_cnt;
  logic [TW-1:0]     tmr_q;
  logic              last_rd, go, full, timeout, err_set;

  assign last_rd = (ch_q == CW'(CH-1)) && (col_q == XW'(IMG_W-1)) && (row_q == YW'(IMG_H-1));
  assign go      = (state_q == S_IDLE) && start && !abort;
  assign full    = (out_cnt == 24'(OUT_TOTAL));
  // tmr_q counts cycles since DRAIN entry or the latest result
  assign timeout = (state_q == S_DRAIN) && !dw_out_valid && !full && (tmr_q >= TW'(DRAIN_MAX-1));
  assign err_set = timeout
                || (dw_out_valid && ((state_q == S_IDLE) || (state_q == S_DONE)))
                || (dw_out_valid && busy && (out_cnt >= 24'(OUT_TOTAL)));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;

  always_comb begin
    state_d = state_q;
    fm_ren  = (state_q == S_ISSUE) && !hold;
    busy    = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    done    = (state_q == S_DONE);
    case (state_q)
      S_IDLE:  if (start) state_d = S_ISSUE;
      S_ISSUE: if (fm_ren && last_rd) state_d = S_DRAIN;
      S_DRAIN: if (full || timeout) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ch_q <= '0; col_q <= '0; row_q <= '0; addr_q <= '0; out_cnt <= '0; tmr_q <= '0;
    end else if (abort || go) begin
      ch_q <= '0; col_q <= '0; row_q <= '0; addr_q <= '0; out_cnt <= '0; tmr_q <= '0;
    end else begin
      if (fm_ren) begin
        addr_q <= last_rd ? '0 : addr_q + ADDR_W'(1);
        if (ch_q == CW'(CH-1)) begin
          ch_q <= '0;
          if (col_q == XW'(IMG_W-1)) begin
            col_q <= '0;
            row_q <= (row_q == YW'(IMG_H-1)) ? '0 : row_q + YW'(1);
          end else col_q <= col_q + XW'(1);
        end else ch_q <= ch_q + CW'(1);
      end
      if (busy && dw_out_valid) out_cnt <= out_cnt + 24'd1;
      if (state_q == S_ISSUE) tmr_q <= TW'(1);
      else if (state_q == S_DRAIN) begin
        if (dw_out_valid)                tmr_q <= TW'(1);
        else if (tmr_q != TW'(DRAIN_MAX)) tmr_q <= tmr_q + TW'(1);
      end
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)       err <= 1'b0;
    else if (go)      err <= 1'b0;
    else if (err_set) err <= 1'b1;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) dw_in_valid <= 1'b0;
    else        dw_in_valid <= fm_ren;

  assign fm_addr    = addr_q;
  assign wt_ren     = fm_ren;
  assign wt_addr    = 8'(ch_q);
  assign dw_in_data = fm_rdata;
  assign dw_weight  = wt_rdata;
  assign dw_bias    = bias_rdata;

`ifdef DWCONV_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (go) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else begin
      if (busy) perf_cycles <= perf_cycles + 32'd1;
      if ((state_q == S_ISSUE) && hold) perf_stalls <= perf_stalls + 32'd1;
    end
`endif
endmodule

// File: tb/tb_dwconv_seq.sv
// Randomized bench for dwconv_seq on a 4x3x2 frame with SRAM/ROM models and a frame-level reference.
module tb_dwconv_seq;
  localparam int W = 4, H = 3, C = 2, AW = 5, OT = 4, DM = 16;
  localparam int NPIX = W*H*C;

  logic clk = 0, rst_n = 0;
  logic start = 0, abort = 0, hold = 0, dw_out_valid = 0;
  logic fm_ren, wt_ren, dw_in_valid, busy, done, err;
  logic [AW-1:0] fm_addr;
  logic [7:0] wt_addr;
  logic [15:0] fm_rdata = 0, bias_rdata = 0, dw_in_data, dw_bias;
  logic [143:0] wt_rdata = 0, dw_weight;
`ifdef DWCONV_SEQ_PERF_EN
  logic [31:0] perf_cycles, perf_stalls;
`endif

  dwconv_seq #(.IMG_W(W), .IMG_H(H), .CH(C), .ADDR_W(AW), .OUT_TOTAL(OT), .DRAIN_MAX(DM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .hold(hold),
    .fm_ren(fm_ren), .fm_addr(fm_addr), .fm_rdata(fm_rdata),
    .wt_ren(wt_ren), .wt_addr(wt_addr), .wt_rdata(wt_rdata), .bias_rdata(bias_rdata),
    .dw_in_valid(dw_in_valid), .dw_in_data(dw_in_data), .dw_weight(dw_weight), .dw_bias(dw_bias),
    .dw_out_valid(dw_out_valid), .busy(busy), .done(done), .err(err)
`ifdef DWCONV_SEQ_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  logic [15:0]  fmmem [NPIX];
  logic [143:0] wtmem [C];
  logic [15:0]  bmem  [C];

  always @(posedge clk) begin
    if (fm_ren) fm_rdata <= fmmem[fm_addr];
    if (wt_ren) begin
      wt_rdata   <= wtmem[wt_addr];
      bias_rdata <= bmem[wt_addr];
    end
  end

  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  // frame-level reference: linear address order, channel = addr mod C, beat one cycle after issue
  int exp_addr, issues, beats, busy_cnt, stall_cnt, done_cnt = 0;
  int first_cyc, last_cyc, res_cyc, done_cyc;
  bit prev_ren = 0, prev_done = 0;
  int prev_addr = 0;

  always @(negedge clk) if (rst_n) begin
    chk("beat_vld", dw_in_valid, prev_ren);
    if (dw_in_valid) begin
      chk("beat_data", dw_in_data, fmmem[prev_addr]);
      chk("beat_wt", dw_weight, wtmem[prev_addr % C]);
      chk("beat_bias", dw_bias, bmem[prev_addr % C]);
      beats++;
    end
    if (busy) busy_cnt++;
    if (busy && hold && issues < NPIX) stall_cnt++;
    if (fm_ren) begin
      chk("fm_addr", fm_addr, exp_addr);
      chk("wt_addr", wt_addr, exp_addr % C);
      chk("wt_ren", wt_ren, 1);
      if (issues == 0) first_cyc = cyc;
      last_cyc = cyc;
      exp_addr++;
      issues++;
    end
    if (dw_out_valid) res_cyc = cyc;
    if (done) begin
      chk("done_1cyc", prev_done, 0);
      chk("done_busy", busy, 0);
      done_cnt++;
      done_cyc = cyc;
    end
    prev_done = done;
    prev_ren  = fm_ren;
    prev_addr = fm_addr;
  end

  task automatic clr_ref();
    exp_addr = 0; issues = 0; beats = 0; busy_cnt = 0; stall_cnt = 0;
  endtask

  task automatic start_frame();
    @(posedge clk); #1;
    clr_ref();
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic pulse_res();
    dw_out_valid = 1;
    @(posedge clk); #1;
    dw_out_valid = 0;
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int maxc);
    int d0, n;
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", done_cnt - d0, 1);
  endtask

  task automatic wait_issued(input int maxc);
    int n;
    n = 0;
    while (issues < NPIX && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    chk("issued", issues, NPIX);
  endtask

  initial begin
    int k, d0;
    for (int i = 0; i < NPIX; i++) fmmem[i] = 16'($urandom);
    for (int i = 0; i < C; i++) begin
      wtmem[i] = {$urandom, $urandom, $urandom, $urandom, $urandom};
      bmem[i]  = 16'($urandom);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ren", fm_ren, 0);   chk("rst_vld", dw_in_valid, 0);
    chk("rst_busy", busy, 0);    chk("rst_done", done, 0);
    chk("rst_err", err, 0);      chk("rst_addr", fm_addr, 0);
    chk("rst_wt", wt_addr, 0);
`ifdef DWCONV_SEQ_PERF_EN
    chk("rst_pcyc", perf_cycles, 0); chk("rst_pstl", perf_stalls, 0);
`endif
    rst_n = 1;

    // frame 1: no hold, start latency, stray starts during ISSUE
    @(posedge clk); #1;
    clr_ref();
    start = 1;
    @(negedge clk); chk("t0_ren", fm_ren, 0);
    @(posedge clk); #1 start = 0;
    @(negedge clk); chk("t1_ren", fm_ren, 1); chk("t1_busy", busy, 1);
    @(negedge clk); chk("t2_beat", dw_in_valid, 1);
    k = 0;
    while (issues < NPIX && k < 100) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 3) == 0);
      k++;
    end
    start = 0;
    chk("f1_issued", issues, NPIX);
    chk("f1_span", last_cyc - first_cyc, NPIX - 1);
    repeat (2) @(posedge clk);
    #1;
    repeat (OT) pulse_res();
    wait_done(10);
    chk("f1_err", err, 0);
    chk("f1_beats", beats, NPIX);

    // frame 2: hold on ISSUE cycles 3..5
    start_frame();
    k = 1;
    while (issues < NPIX && k < 100) begin
      hold = (k >= 3 && k <= 5);
      @(posedge clk); #1;
      k++;
    end
    hold = 0;
    chk("f2_issued", issues, NPIX);
    chk("f2_span", last_cyc - first_cyc, NPIX + 2);
    repeat (2) @(posedge clk);
    #1;
    chk("f2_beats", beats, NPIX);
    repeat (OT) pulse_res();
    wait_done(10);
    chk("f2_err", err, 0);
`ifdef DWCONV_SEQ_PERF_EN
    repeat (3) @(posedge clk);
    #1;
    chk("f2_pstl", perf_stalls, 3);
    chk("f2_pcyc", perf_cycles, busy_cnt);
`endif

    // frame 3: abort while address 10 is issued
    start_frame();
    k = 0;
    while (!(fm_ren && fm_addr == 10) && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    d0 = done_cnt;
    repeat (20) @(posedge clk);
    #1;
    chk("ab_issues", issues, 11);
    chk("ab_beats", beats, 11);
    chk("ab_busy", busy, 0);
    chk("ab_nodone", done_cnt - d0, 0);

    // frame 4: restart from 0, only 3 results -> DRAIN timeout
    start_frame();
    wait_issued(60);
    repeat (2) @(posedge clk);
    #1;
    repeat (OT - 1) pulse_res();
    wait_done(40);
    chk("to_gap", done_cyc - res_cyc, DM);
    chk("to_err", err, 1);

    // frame 5: err clears on start; random hold; 5 results during ISSUE overflow
    start_frame();
    chk("clr_err", err, 0);
    k = 1;
    while (issues < NPIX && k < 200) begin
      hold = ($urandom_range(0, 2) == 0);
      dw_out_valid = (k % 2 == 0) && (k <= 10);
      if (k == 9) chk("ovf_pre", err, 0);
      @(posedge clk); #1;
      k++;
    end
    hold = 0;
    dw_out_valid = 0;
    chk("f5_issued", issues, NPIX);
    chk("ovf_err", err, 1);
    wait_done(60);
    chk("f5_beats", beats, NPIX);
    chk("f5_err", err, 1);
`ifdef DWCONV_SEQ_PERF_EN
    chk("f5_pstl", perf_stalls, stall_cnt);
    chk("f5_pcyc", perf_cycles, busy_cnt);
`endif

    // frame 6: immediate abort, then a result in IDLE flags err
    start_frame();
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    chk("f6_err", err, 0);
    chk("f6_busy", busy, 0);
    pulse_res();
    chk("idle_res_err", err, 1);

    // start with abort: stays idle
    start = 1; abort = 1;
    @(posedge clk); #1;
    start = 0; abort = 0;
    chk("sa_busy", busy, 0);
    chk("sa_ren", fm_ren, 0);
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
endmodule
